// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity checker.
package serial_parity_pkg;

    // Frame-reception states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Parity-mode encodings as seen on odd_mode.
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // A frame is good when the XOR over data and parity bits equals the mode bit.
    function automatic logic parity_ok(input logic xor_all, input logic mode);
        return xor_all == mode;
    endfunction

endpackage

// File: rtl/serial_parity_checker_if.sv
// Bundle of the serial parity checker's data-path signals.
//
// Handshake: there is no back-pressure. A bit is transferred on every rising
// clk edge where bit_valid is high; serial_in and frame_start are only
// meaningful in such cycles. frame_valid is a one-cycle pulse with no ready,
// so the consumer must take data_out/parity_err while it is high (they are
// also held until the next frame completes).
interface serial_parity_checker_if
    import serial_parity_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int ERR_CNT_W = 8
);
    logic                 bit_valid;
    logic                 serial_in;
    logic                 frame_start;
    logic                 odd_mode;
    logic                 err_clr;
    logic [DATA_BITS-1:0] data_out;
    logic                 frame_valid;
    logic                 parity_err;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 busy;
    logic                 live_parity;
    state_t               fsm_state;

    modport master (
        output bit_valid, serial_in, frame_start, odd_mode, err_clr,
        input  data_out, frame_valid, parity_err, err_count, busy, live_parity,
        input  fsm_state
    );

    modport slave (
        input  bit_valid, serial_in, frame_start, odd_mode, err_clr,
        output data_out, frame_valid, parity_err, err_count, busy, live_parity,
        output fsm_state
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count up to all-ones and stick there until cleared.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Receives LSB-first serial frames of DATA_BITS data bits plus one parity
// bit, reports the frame and its parity result, and counts errored frames.
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int ERR_CNT_W = 8
) (
    input logic                    clk,
    input logic                    reset,
    serial_parity_checker_if.slave bus
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    state_t               state_q, state_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic                 odd_q, odd_n;
    logic                 live_q, live_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 perr_q, perr_n;
    logic                 fv_q;
    logic                 done;
    logic                 err;

    // Next-state and data-path decode; frame_start with bit_valid always restarts.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        shift_n = shift_q;
        odd_n   = odd_q;
        live_n  = live_q;
        data_n  = data_q;
        perr_n  = perr_q;
        done    = 1'b0;
        err     = 1'b0;
        if (bus.bit_valid) begin
            if (bus.frame_start) begin
                // New frame (or abort-restart): sampled bit becomes bit 0.
                shift_n    = '0;
                shift_n[0] = bus.serial_in;
                idx_n      = IDX_W'(1);
                odd_n      = bus.odd_mode ? ODD : EVEN;
                live_n     = bus.serial_in;
                state_n    = (DATA_BITS == 1) ? PARITY : DATA;
            end else begin
                case (state_q)
                    IDLE: begin
                        // Stray bits outside a frame are dropped.
                    end
                    DATA: begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (IDX_W'(i) == idx_q) begin
                                shift_n[i] = bus.serial_in;
                            end
                        end
                        live_n = live_q ^ bus.serial_in;
                        idx_n  = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                            state_n = PARITY;
                        end
                    end
                    PARITY: begin
                        done    = 1'b1;
                        err     = !parity_ok(live_q ^ bus.serial_in, odd_q);
                        data_n  = shift_q;
                        perr_n  = err;
                        idx_n   = '0;
                        live_n  = 1'b0;
                        state_n = IDLE;
                    end
                    default: begin
                        state_n = IDLE;
                        idx_n   = '0;
                        live_n  = 1'b0;
                    end
                endcase
            end
        end
    end

    // State and data-path registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            odd_q   <= EVEN;
            live_q  <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            shift_q <= shift_n;
            odd_q   <= odd_n;
            live_q  <= live_n;
            data_q  <= data_n;
            perr_q  <= perr_n;
            fv_q    <= done;
        end
    end

    sat_counter #(
        .WIDTH(ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (done && err),
        .clr   (bus.err_clr),
        .count (bus.err_count)
    );

    assign bus.data_out    = data_q;
    assign bus.frame_valid = fv_q;
    assign bus.parity_err  = perr_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.live_parity = live_q;
    assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker with DATA_BITS=8, ERR_CNT_W=2.
module tb_serial_parity_checker;
    import serial_parity_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   fv_seen;
    int   fv_exp;
    int   exp_cnt;
    bit   pending;
    logic [10:0] exp_q[$];

    serial_parity_checker_if #(.DATA_BITS(8), .ERR_CNT_W(2)) bus ();

    serial_parity_checker #(
        .DATA_BITS(8),
        .ERR_CNT_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Count every frame_valid pulse the DUT produces.
    always @(posedge clk) begin
        if (bus.frame_valid === 1'b1) fv_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any frame that just completed.
    task automatic tick();
        logic [10:0] item;
        @(negedge clk);
        if (pending) begin
            pending = 0;
            chk("frame_valid", 32'(bus.frame_valid), 32'd1);
            if (exp_q.size() == 0) begin
                chk("queue_nonempty", 32'd0, 32'd1);
            end else begin
                item = exp_q.pop_front();
                chk("data_out", 32'(bus.data_out), 32'(item[10:3]));
                chk("parity_err", 32'(bus.parity_err), 32'(item[2]));
                chk("err_count", 32'(bus.err_count), 32'(item[1:0]));
            end
            chk("live_after_frame", 32'(bus.live_parity), 32'd0);
        end
    endtask

    task automatic drive(input logic bv, input logic sin, input logic fs,
                         input logic odd, input logic clr);
        bus.bit_valid   = bv;
        bus.serial_in   = sin;
        bus.frame_start = fs;
        bus.odd_mode    = odd;
        bus.err_clr     = clr;
    endtask

    task automatic idle(input logic clr);
        tick();
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, clr);
    endtask

    // Full frame; odd_mode is randomised after bit 0 since it must be ignored.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic odd_m,
                              input bit toggle, input logic clr);
        logic lp;
        logic err_m;
        lp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i > 0) begin
                chk("live_parity", 32'(bus.live_parity), 32'(lp));
                chk("busy", 32'(bus.busy), 32'd1);
            end
            drive(1'b1, d[i], (i == 0), (i == 0) ? odd_m : 1'($urandom_range(0, 1)), 1'b0);
            lp = lp ^ d[i];
            if (toggle) begin
                tick();
                drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0);
            end
        end
        tick();
        chk("live_before_parity", 32'(bus.live_parity), 32'(lp));
        chk("state_parity", 32'(bus.fsm_state), 32'(PARITY));
        drive(1'b1, par, 1'b0, ~odd_m, clr);
        err_m = ((^d) ^ par) != odd_m;
        if (clr) exp_cnt = 0;
        else if (err_m && exp_cnt < 3) exp_cnt++;
        exp_q.push_back({d, err_m, 2'(exp_cnt)});
        fv_exp++;
        pending = 1;
    endtask

    task automatic partial(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            drive(1'b1, d[i], (i == 0), 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic       rodd;
        checks  = 0;
        errors  = 0;
        fv_seen = 0;
        fv_exp  = 0;
        exp_cnt = 0;
        pending = 0;
        reset   = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        chk("rst_parity_err", 32'(bus.parity_err), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_live", 32'(bus.live_parity), 32'd0);
        chk("rst_state", 32'(bus.fsm_state), 32'(IDLE));
        reset = 1'b0;

        // Bits without frame_start in IDLE are ignored.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("idle_ignore_busy", 32'(bus.busy), 32'd0);
        chk("idle_ignore_live", 32'(bus.live_parity), 32'd0);

        // Good even frame, then errored even, then odd-mode good, back-to-back.
        send_frame(8'hA5, 1'b0, EVEN, 0, 1'b0);
        send_frame(8'hA5, 1'b1, EVEN, 0, 1'b0);
        send_frame(8'hA5, 1'b1, ODD, 0, 1'b0);
        idle(1'b0);

        // Gapped frame.
        send_frame(8'h3C, 1'b0, EVEN, 1, 1'b0);
        idle(1'b0);

        // Abort after 4 data bits, then a complete frame.
        partial(8'h5A, 4);
        send_frame(8'h81, 1'b0, EVEN, 0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("abort_fv_count", 32'(fv_seen), 32'(fv_exp));
        chk("abort_err_count", 32'(bus.err_count), 32'd1);

        // Clear, then saturation with a 2-bit counter.
        idle(1'b1);
        exp_cnt = 0;
        idle(1'b0);
        chk("clr_err_count", 32'(bus.err_count), 32'd0);
        for (int k = 0; k < 4; k++) begin
            rd = 8'($urandom_range(0, 255));
            send_frame(rd, ~(^rd), EVEN, 0, 1'b0);
        end
        rd = 8'($urandom_range(0, 255));
        send_frame(rd, ~(^rd), EVEN, 0, 1'b1);
        idle(1'b0);

        // Reset in the middle of a frame.
        partial(8'h55, 5);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_live", 32'(bus.live_parity), 32'd0);
        chk("midrst_fv", 32'(bus.frame_valid), 32'd0);
        chk("midrst_data_out", 32'(bus.data_out), 32'd0);
        chk("midrst_err_count", 32'(bus.err_count), 32'd0);
        reset   = 1'b0;
        exp_cnt = 0;
        send_frame(8'hFF, 1'b0, EVEN, 0, 1'b0);
        idle(1'b0);

        // Random back-to-back frames with random mode and parity.
        for (int k = 0; k < 4; k++) begin
            rd   = 8'($urandom_range(0, 255));
            rodd = 1'($urandom_range(0, 1));
            send_frame(rd, 1'($urandom_range(0, 1)), rodd, bit'($urandom_range(0, 1)), 1'b0);
        end
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("final_fv_count", 32'(fv_seen), 32'(fv_exp));
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 8, number of data bits per frame (legal 1..32).
REQ-002 The module SHALL have parameter ERR_CNT_W, default 8, width of the parity-error counter (legal 1..16).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bit_valid  input  1  serial_in is sampled this cycle when high.
REQ-006 serial_in  input  1  serial data bit, LSB first, followed by one parity bit.
REQ-007 frame_start  input  1  marks the accepted bit as data bit 0; qualified by bit_valid.
REQ-008 odd_mode  input  1  0 = even parity expected, 1 = odd parity expected.
REQ-009 err_clr  input  1  synchronous clear of err_count.
REQ-010 data_out  output  DATA_BITS  last completed frame's data bits.
REQ-011 frame_valid  output  1  one-cycle pulse, frame complete.
REQ-012 parity_err  output  1  parity result of the last frame, valid with and held after frame_valid.
REQ-013 err_count  output  ERR_CNT_W  saturating count of frames with parity errors.
REQ-014 busy  output  1  high in DATA or PARITY state.
REQ-015 live_parity  output  1  XOR of data bits accepted so far in the current frame; 0 in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, DATA and PARITY.
REQ-017 IDLE: bit_valid&&frame_start SHALL store serial_in as bit 0, latch odd_mode, and go to DATA (or PARITY when DATA_BITS==1); bit_valid without frame_start SHALL be ignored.
REQ-018 DATA: each bit_valid SHALL store serial_in at the next bit index; after bit DATA_BITS-1 the state SHALL become PARITY.
REQ-019 PARITY: bit_valid SHALL sample the parity bit and return to IDLE.
REQ-020 Cycles with bit_valid low SHALL hold state, bit index and shift contents.
REQ-021 Frame OK when XOR(data bits, parity bit) equals latched odd_mode; otherwise parity_err=1.
REQ-022 data_out, parity_err and frame_valid SHALL update in the cycle after the parity bit is sampled (1-cycle latency); data_out/parity_err hold until the next frame completes.
REQ-023 odd_mode changes mid-frame SHALL not affect the current frame.
REQ-024 bit_valid&&frame_start in DATA or PARITY SHALL abort the current frame without frame_valid or error count, and restart with the sampled bit as bit 0.
REQ-025 A new frame_start in the same cycle frame_valid is asserted SHALL be accepted (back-to-back frames, no dead cycle).
REQ-026 err_count SHALL increment by 1 per errored frame, with frame_valid, and saturate at all-ones.
REQ-027 err_clr SHALL zero err_count; err_clr coincident with an error increment SHALL result in 0.
REQ-028 live_parity SHALL reflect data bits accepted through the previous clock edge and clear on frame completion or abort-restart (set to the new bit 0).

Reset
REQ-029 Reset SHALL force IDLE, bit index 0, data_out=0, frame_valid=0, parity_err=0, err_count=0, busy=0, live_parity=0.
REQ-030 Reset SHALL take priority over all inputs, including mid-frame; a partial frame SHALL be discarded without frame_valid.

Structure
REQ-031 A package serial_parity_pkg SHALL hold the state enum type and the parity-mode constants EVEN=0, ODD=1.
REQ-032 The error counter SHALL be a sub-module sat_counter (parameter WIDTH; inputs inc, clr; output count; clr priority).
REQ-033 The bit index width SHALL be $clog2(DATA_BITS+1).

Verification
REQ-034 DATA_BITS=8, even, data 0xA5 LSB first, parity 0 -> frame_valid 1 cycle after parity bit, data_out=0xA5, parity_err=0, err_count=0.
REQ-035 Same frame with parity 1 -> parity_err=1, err_count=1; repeat in odd mode with parity 1 -> parity_err=0, err_count stays 1.
REQ-036 bit_valid toggled 1/0 every cycle through frame 0x3C -> identical result to continuous frame, frame_valid 1 cycle after the last valid bit.
REQ-037 frame_start reasserted after 4 data bits, then full frame 0x81 parity 0 -> one frame_valid only, data_out=0x81, no error count.
REQ-038 ERR_CNT_W=2, four errored frames -> err_count 1,2,3,3; err_clr with fifth errored frame -> err_count=0.
REQ-039 reset asserted after 5 data bits -> busy=0, no frame_valid; subsequent frame 0xFF parity 0 -> data_out=0xFF, parity_err=0.
